// File: rtl/spu_seq_pkg.sv
// Shared state type, prog_data field layout and SPU constants for the SPU command sequencer.
package spu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // prog_data = {Op[15:12], Q[11:8], data[7:0]}; the SPU command byte is {Op,Q}.
    localparam int PD_OP_MSB   = 15;
    localparam int PD_Q_LSB    = 8;
    localparam int PD_DATA_MSB = 7;
    localparam int PD_DATA_LSB = 0;

    localparam int         RESULT_LATENCY = 2;
    localparam logic [7:0] SPU_NOP        = 8'h00;

    function automatic logic [7:0] pd_cmd(input logic [15:0] entry);
        return entry[PD_OP_MSB:PD_Q_LSB];
    endfunction

    function automatic logic [7:0] pd_data(input logic [15:0] entry);
        return entry[PD_DATA_MSB:PD_DATA_LSB];
    endfunction

endpackage

// File: rtl/spu_seq_fifo.sv
// Synchronous first-word-fall-through FIFO holding SPU results until they are read out.
module spu_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!w_full || w_do_pop);
    assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/spu_cmd_sequencer.sv
// Loads a short SPU program, replays it one entry per cycle and buffers the results.
// Optional macro SPU_SEQ_CKSUM_EN adds the cksum output (XOR of results since the last start).
module spu_cmd_sequencer
    import spu_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ena,
    input  logic                     prog_valid,
    output logic                     prog_ready,
    input  logic [15:0]              prog_data,
    input  logic                     start,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               spu_cmd,
    output logic [7:0]               spu_data,
    input  logic [7:0]               spu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
`ifdef SPU_SEQ_CKSUM_EN
    output logic [7:0]               cksum,
`endif
    output logic [1:0]               dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_prog_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshakes: a transfer happens on an edge where valid && ready are both high;
    // prog_ready drops while ena is low so no load is offered that would be ignored.

    seq_state_t                r_state;
    logic [15:0]               r_prog [DEPTH];
    logic [CW-1:0]             r_count;
    logic [CW-1:0]             r_idx;
    logic [RESULT_LATENCY-1:0] r_vld;
    logic [7:0]                r_cmd;
    logic [7:0]                r_data;
    logic                      r_done;
    logic                      r_busy;

    logic w_prog_wr;
    logic w_start_ok;
    logic w_issue;
    logic w_push;
    logic w_pop;
    logic w_fifo_empty;

    assign prog_ready = ena && (r_state == ST_IDLE) && (r_count < CW'(DEPTH));
    assign w_prog_wr  = prog_valid && prog_ready;
    assign w_start_ok = ena && (r_state == ST_IDLE) && start && !clear && w_fifo_empty;
    assign w_issue    = (r_state == ST_RUN) && (r_idx != r_count);
    assign w_push     = ena && r_vld[RESULT_LATENCY-1];
    assign res_valid  = !w_fifo_empty;
    assign w_pop      = res_valid && res_ready;

    assign spu_cmd        = r_cmd;
    assign spu_data       = r_data;
    assign done           = r_done;
    assign busy           = r_busy;
    assign dbg_state      = r_state;
    assign dbg_prog_count = r_count;

    // Program store has no reset: it survives runs so the same program can be replayed.
    always_ff @(posedge clk) begin
        if (w_prog_wr) r_prog[r_count[AW-1:0]] <= prog_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_vld   <= '0;
            r_cmd   <= SPU_NOP;
            r_data  <= SPU_NOP;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (ena) begin
            r_vld  <= {r_vld[RESULT_LATENCY-2:0], w_issue};
            r_cmd  <= SPU_NOP;
            r_data <= SPU_NOP;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clear) begin
                        r_count <= '0;
                    end else begin
                        if (w_prog_wr) r_count <= r_count + 1'b1;
                        if (w_start_ok) begin
                            r_idx  <= '0;
                            r_busy <= 1'b1;
                            if (r_count == '0) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_cmd  <= pd_cmd(r_prog[r_idx[AW-1:0]]);
                        r_data <= pd_data(r_prog[r_idx[AW-1:0]]);
                        r_idx  <= r_idx + 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_vld == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPU_SEQ_CKSUM_EN
    logic [7:0] r_cksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_cksum <= 8'h00;
        else if (w_start_ok) r_cksum <= 8'h00;
        else if (w_push)     r_cksum <= r_cksum ^ spu_result;
    end

    assign cksum = r_cksum;
`endif

    spu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_res_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_push_data (spu_result),
        .i_pop       (w_pop),
        .o_pop_data  (res_data),
        .o_empty     (w_fifo_empty)
    );

endmodule

// File: doc/spu_cmd_sequencer.md
SPU_CMD_SEQUENCER -- requirements
Module: spu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning program and result entries (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ena, input, 1, global enable; low freezes all sequencer state.
REQ-005 SHALL have ports prog_valid (in, 1), prog_ready (out, 1) and prog_data (in, 16, {Op[15:12], Q[11:8], data[7:0]}), the program load handshake.
REQ-006 SHALL have ports start (in, 1), clear (in, 1), busy (out, 1) and done (out, 1), the run control.
REQ-007 SHALL have ports spu_cmd (out, 8, {Op,Q}), spu_data (out, 8) and spu_result (in, 8, {M,N}), the SPU command side.
REQ-008 SHALL have ports res_valid (out, 1), res_ready (in, 1) and res_data (out, 8), the result readout handshake.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DRAIN and DONE; all transitions occur only on edges where ena=1.
REQ-010 IDLE: prog_ready=1 iff program count<DEPTH; a write occurs when prog_valid&&prog_ready and the entry goes to address count, which then increments.
REQ-011 prog_ready SHALL be 0 outside IDLE; a full program ignores further writes.
REQ-012 clear in IDLE SHALL zero the program count in one cycle; clear outside IDLE SHALL be ignored.
REQ-013 start in IDLE with result buffer empty SHALL enter RUN (count>0) or DONE (count=0); start is ignored otherwise, and clear takes priority over start.
REQ-014 RUN: entry i SHALL drive spu_cmd/spu_data in cycle i+1 after the start edge; after the last entry, enter DRAIN.
REQ-015 Outside RUN, spu_cmd and spu_data SHALL be 8'h00 (SPU NOP/hold).
REQ-016 Result latency SHALL be 2: spu_result is pushed into the result buffer at the second edge after the edge that presents an entry to the SPU, tracked by a 2-stage valid shift register.
REQ-017 DRAIN SHALL last until the in-flight valid pipeline is empty, then enter DONE; DONE lasts one cycle with done=1, then returns to IDLE.
REQ-018 For a program of N entries started at edge 0 with ena held high, done SHALL be high exactly during the cycle after edge N+3.
REQ-019 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-020 The result buffer SHALL be a DEPTH-entry FIFO; it pops on res_valid&&res_ready, with res_valid=!empty; it cannot overflow because start requires an empty buffer.
REQ-021 Reads SHALL be allowed in any state; a simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-022 The program SHALL be retained after a run so it can be replayed by another start.
REQ-023 ena=0 mid-run SHALL hold the issue index, pipeline and outputs; this is safe because SPU outputs are stable under held commands.

Reset
REQ-024 On reset: state=IDLE, program count=0, result FIFO empty, pipeline valid bits=0, spu_cmd=spu_data=8'h00, done=busy=res_valid=0, prog_ready=1.
REQ-025 Reset asserted mid-run SHALL abort immediately and discard in-flight results; program contents need not be cleared.

Configuration
REQ-026 Macro SPU_SEQ_CKSUM_EN defined: output cksum (8-bit) = XOR of all results pushed since the last accepted start; cleared at start and at reset.
REQ-027 Macro SPU_SEQ_CKSUM_EN undefined: the cksum port and its logic SHALL be absent.

Structure
REQ-028 Package spu_seq_pkg SHALL hold the state enum, prog_data field positions, the RESULT_LATENCY=2 constant and the SPU_NOP=8'h00 constant.
REQ-029 The result buffer SHALL be a sub-module spu_seq_fifo (parameterised synchronous FIFO); the program store is inline.

Verification
REQ-030 Load 3 entries {0x0700,0x3000,0x0000} after reset, start, SPU model attached -> spu_cmd 0x07,0x30,0x00 in consecutive cycles; done in cycle after edge 6; 3 results read in issue order matching the model.
REQ-031 Write 9 entries with DEPTH=8 -> prog_ready drops after the 8th; the 9th is not stored; count=8.
REQ-032 start with count=0 -> done pulses the next cycle; no results are pushed; spu_cmd stays 0x00.
REQ-033 Run of 4 with ena low for 3 cycles mid-RUN -> results equal the ena-always-high run; done is delayed by 3 cycles.
REQ-034 Reset asserted during DRAIN -> next cycle: IDLE, res_valid=0, busy=0; a second start with results still unread is ignored until the FIFO is drained.
REQ-035 With SPU_SEQ_CKSUM_EN: results 0x12,0x34,0x0F -> cksum=0x29; cksum=0x00 after the next start.
